// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result valid-ready handshake bundle for alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             err;
  modport master (
    output in_valid, alucontrol, a, b, out_ready,
    input  in_ready, out_valid, result, hi, zero, err
  );
  modport slave (
    input  in_valid, alucontrol, a, b, out_ready,
    output in_ready, out_valid, result, hi, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU ops plus iterative MULU and, with ALU_SEQ_DIV_EN defined, DIVU
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic   clk,
  input  logic   reset_n,
  alu_seq_if.slave bus
);
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000001;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SLT  = 6'b100011;
  localparam logic [5:0] OP_MULU = 6'b011001;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [5:0] OP_DIVU = 6'b011011;
`endif
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
`ifdef ALU_SEQ_DIV_EN
    , DIV
`endif
  } state_t;
  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_sh;
`endif
  // MUL: hi_q accumulates, result_q holds the multiplier shifting out as product bits shift in
  // DIV: hi_q is the partial remainder, result_q holds the dividend shifting out as quotient bits shift in
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    err_d    = err_q;
    mul_sum  = {1'b0, hi_q} + (result_q[0] ? {1'b0, op_q} : '0);
`ifdef ALU_SEQ_DIV_EN
    div_sh   = {hi_q, result_q[WIDTH-1]};
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = DONE;
        cnt_d   = CNTW'(WIDTH);
        hi_d    = '0;
        err_d   = 1'b0;
        case (bus.alucontrol)
          OP_AND:  result_d = bus.a & bus.b;
          OP_OR:   result_d = bus.a | bus.b;
          OP_ADD:  result_d = bus.a + bus.b;
          OP_SUB:  result_d = bus.a - bus.b;
          OP_SLT:  result_d = WIDTH'($signed(bus.a) < $signed(bus.b));
          OP_MULU: begin
            state_d  = MUL;
            op_d     = bus.a;
            result_d = bus.b;
          end
`ifdef ALU_SEQ_DIV_EN
          OP_DIVU: if (bus.b == '0) begin
            result_d = '1;
            hi_d     = bus.a;
            err_d    = 1'b1;
          end else begin
            state_d  = DIV;
            op_d     = bus.b;
            result_d = bus.a;
          end
`endif
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
        zero_d = result_d == '0;
      end
      MUL: begin
        {hi_d, result_d} = {mul_sum, result_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CNTW'(1);
        zero_d  = result_d == '0;
        state_d = (cnt_q == CNTW'(1)) ? DONE : MUL;
      end
`ifdef ALU_SEQ_DIV_EN
      DIV: begin
        hi_d     = (div_sh >= {1'b0, op_q}) ? WIDTH'(div_sh - {1'b0, op_q}) : div_sh[WIDTH-1:0];
        result_d = {result_q[WIDTH-2:0], div_sh >= {1'b0, op_q}};
        cnt_d    = cnt_q - CNTW'(1);
        zero_d   = result_d == '0;
        state_d  = (cnt_q == CNTW'(1)) ? DONE : DIV;
      end
`endif
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result    = result_q;
  assign bus.hi        = hi_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
endmodule
